// File: rtl/uart_rx_module_if.sv
// Receiver-side signal bundle: serial line and enable in, byte and strobes out.
interface uart_rx_module_if;
    logic       RX_Pin_In;
    logic       RX_En_Sig;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       Frame_Err_Sig;
    logic       RX_Busy;

    // The receiver consumes the line and enable and produces the byte and strobes.
    modport slave (
        input  RX_Pin_In,
        input  RX_En_Sig,
        output RX_Data,
        output RX_Done_Sig,
        output Frame_Err_Sig,
        output RX_Busy
    );

    // The line driver / consumer side.
    modport master (
        output RX_Pin_In,
        output RX_En_Sig,
        input  RX_Data,
        input  RX_Done_Sig,
        input  Frame_Err_Sig,
        input  RX_Busy
    );
endinterface

// File: rtl/uart_rx_module.sv
// UART 8N1 receiver: synchronises the line, times bits with a BPS counter,
// samples mid-bit, assembles a byte LSB first and strobes done or framing error.
module uart_rx_module #(
    parameter int BPS_T  = 52,
    parameter int HALF_T = BPS_T / 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    uart_rx_module_if.slave   rx_if
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic        s1_q, s2_q, s3_q;
    logic [2:0]  state_q, state_d;
    logic [12:0] count_q, count_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic rxs;
    logic fall;
    logic sample_pt;
    logic wrap_pt;

    assign rxs       = s2_q;
    assign fall      = s3_q & ~s2_q;
    assign sample_pt = (count_q == 13'(HALF_T));
    assign wrap_pt   = (count_q == 13'(BPS_T - 1));

    // Two-flop synchroniser on the pin plus a history flop for falling-edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_if.RX_Pin_In;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Next-state logic: bit timing, sampling, framing and enable override.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // The bit timer only runs while a frame is in flight.
        if (state_q == START || state_q == DATA || state_q == STOP) begin
            if (wrap_pt) begin
                count_d = '0;
                bit_d   = bit_q + 4'd1;
            end else begin
                count_d = count_q + 13'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rx_if.RX_En_Sig && fall) begin
                    state_d = START;
                    count_d = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (sample_pt && rxs) begin
                    state_d = IDLE;
                end else if (wrap_pt) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Shift right so the first bit received ends up in bit 0.
                if (sample_pt) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                end
                if (wrap_pt && bit_q == 4'd8) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave half a bit early so a back-to-back start edge is not missed.
                if (sample_pt) begin
                    if (rxs) begin
                        data_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A break holds the line low; wait for it to return before rearming.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling the receiver aborts any frame silently.
        if (!rx_if.RX_En_Sig && state_q != IDLE) begin
            state_d = IDLE;
            data_d  = data_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Receiver state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            count_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_if.RX_Data       = data_q;
    assign rx_if.RX_Done_Sig   = done_q;
    assign rx_if.Frame_Err_Sig = err_q;
    assign rx_if.RX_Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for the UART 8N1 receiver at 52 clocks per bit.
module tb_uart_rx_module;

    localparam int BPS = 52;
    localparam int LAT = 498;  // pin drive cycle to strobe cycle (2 sync + 496)

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    uart_rx_module_if rx_if ();

    uart_rx_module #(.BPS_T(52), .HALF_T(26)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .rx_if (rx_if)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe / busy monitor sampled on the falling edge.
    int         done_cyc[$];
    logic [7:0] done_dat[$];
    int         err_cyc[$];
    int         both_high   = 0;
    int         busy_fall   = -1;
    int         busy_hi_cnt = 0;
    logic       busy_prev   = 1'b0;

    always @(negedge CLK) begin
        if (rx_if.RX_Done_Sig === 1'b1) begin
            done_cyc.push_back(cyc);
            done_dat.push_back(rx_if.RX_Data);
        end
        if (rx_if.Frame_Err_Sig === 1'b1) err_cyc.push_back(cyc);
        if (rx_if.RX_Done_Sig === 1'b1 && rx_if.Frame_Err_Sig === 1'b1) both_high++;
        if (busy_prev === 1'b1 && rx_if.RX_Busy === 1'b0) busy_fall = cyc;
        if (rx_if.RX_Busy === 1'b1) busy_hi_cnt++;
        busy_prev = rx_if.RX_Busy;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame; entered and left at posedge+1, bit k starts at cycle t0+52k.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_if.RX_Pin_In = fr[i];
            repeat (BPS) @(posedge CLK);
            #1;
        end
    endtask

    int t0, t1, t2, tg;

    initial begin
        rx_if.RX_Pin_In = 1'b1;
        rx_if.RX_En_Sig = 1'b1;
        RSTn = 1'b0;
        wait_cyc(3);
        @(negedge CLK);
        check("rst_data", rx_if.RX_Data, 8'h00);
        check("rst_done", rx_if.RX_Done_Sig, 1'b0);
        check("rst_err", rx_if.Frame_Err_Sig, 1'b0);
        check("rst_busy", rx_if.RX_Busy, 1'b0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        wait_cyc(5);

        // Single frame: latency, data, busy fall coincident with done.
        send_frame(8'hA5, 1'b1, t0);
        check("a5_ndone", done_cyc.size(), 1);
        check("a5_cyc", done_cyc[0], t0 + LAT);
        check("a5_strobe_dat", done_dat[0], 8'hA5);
        check("a5_data", rx_if.RX_Data, 8'hA5);
        check("a5_nerr", err_cyc.size(), 0);
        check("a5_busy_fall", busy_fall, t0 + LAT);

        // Back-to-back frames with a single stop bit.
        send_frame(8'h3C, 1'b1, t1);
        send_frame(8'hC3, 1'b1, t2);
        check("b2b_ndone", done_cyc.size(), 3);
        check("b2b_cyc1", done_cyc[1], t1 + LAT);
        check("b2b_gap", done_cyc[2] - done_cyc[1], 520);
        check("b2b_dat1", done_dat[1], 8'h3C);
        check("b2b_dat2", done_dat[2], 8'hC3);

        // Framing error, break, then recovery.
        send_frame(8'h55, 1'b0, t0);
        check("fe_nerr", err_cyc.size(), 1);
        check("fe_cyc", err_cyc[0], t0 + LAT);
        check("fe_ndone", done_cyc.size(), 3);
        check("fe_data_kept", rx_if.RX_Data, 8'hC3);
        wait_cyc(200);
        check("brk_busy", rx_if.RX_Busy, 1'b1);
        check("brk_ndone", done_cyc.size(), 3);
        check("brk_nerr", err_cyc.size(), 1);
        rx_if.RX_Pin_In = 1'b1;
        wait_cyc(10);
        check("brk_idle", rx_if.RX_Busy, 1'b0);
        send_frame(8'h0F, 1'b1, t0);
        check("rec_ndone", done_cyc.size(), 4);
        check("rec_dat", done_dat[3], 8'h0F);
        check("rec_data", rx_if.RX_Data, 8'h0F);

        // Ten-cycle low glitch on an idle line.
        wait_cyc(10);
        tg = cyc;
        rx_if.RX_Pin_In = 1'b0;
        wait_cyc(10);
        rx_if.RX_Pin_In = 1'b1;
        check("gl_busy", rx_if.RX_Busy, 1'b1);
        wait_cyc(30);
        check("gl_idle", rx_if.RX_Busy, 1'b0);
        check("gl_fall", busy_fall, tg + 30);
        check("gl_ndone", done_cyc.size(), 4);
        check("gl_nerr", err_cyc.size(), 1);
        check("gl_data", rx_if.RX_Data, 8'h0F);

        // Enable dropped during data bit 4 of 0xFF.
        wait_cyc(10);
        fork
            send_frame(8'hFF, 1'b1, t0);
            begin
                repeat (280) @(posedge CLK);
                #1;
                rx_if.RX_En_Sig = 1'b0;
                @(negedge CLK);
                check("en_busy_before", rx_if.RX_Busy, 1'b1);
                @(posedge CLK);
                @(negedge CLK);
                check("en_busy_after", rx_if.RX_Busy, 1'b0);
            end
        join
        check("en_fall", busy_fall, t0 + 281);
        check("en_ndone", done_cyc.size(), 4);
        check("en_nerr", err_cyc.size(), 1);

        // Full frame with the receiver disabled is ignored.
        busy_hi_cnt = 0;
        send_frame(8'h5A, 1'b1, t0);
        wait_cyc(10);
        check("dis_busy_cnt", busy_hi_cnt, 0);
        check("dis_ndone", done_cyc.size(), 4);
        check("dis_data", rx_if.RX_Data, 8'h0F);
        rx_if.RX_En_Sig = 1'b1;
        wait_cyc(5);

        // Reset during data bit 6 aborts silently.
        fork
            send_frame(8'hC0, 1'b1, t0);
            begin
                repeat (380) @(posedge CLK);
                #1;
                RSTn = 1'b0;
                @(posedge CLK);
                @(negedge CLK);
                check("mr_data", rx_if.RX_Data, 8'h00);
                check("mr_busy", rx_if.RX_Busy, 1'b0);
                check("mr_done", rx_if.RX_Done_Sig, 1'b0);
                check("mr_err", rx_if.Frame_Err_Sig, 1'b0);
                repeat (200) @(posedge CLK);
                #1;
                RSTn = 1'b1;
            end
        join
        check("mr_ndone", done_cyc.size(), 4);
        check("mr_nerr", err_cyc.size(), 1);
        wait_cyc(5);
        send_frame(8'h81, 1'b1, t0);
        check("post_ndone", done_cyc.size(), 5);
        check("post_cyc", done_cyc[4], t0 + LAT);
        check("post_dat", done_dat[4], 8'h81);
        check("post_data", rx_if.RX_Data, 8'h81);

        check("never_both", both_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
- UART 8N1 receiver: the receive-side counterpart to the TX bit-rate generator and TX control path.
- Synchronises the asynchronous RX pin, detects the start bit, times each bit with an internal BPS counter, samples mid-bit, and assembles one byte LSB first.
- Presents the byte with a one-cycle done strobe, or a one-cycle framing-error strobe, to the top-level consumer.
- Same clock domain as the TX path: 500 kHz system clock, 9600 baud.

Parameters:
- BPS_T, 52: clock cycles per bit (500 kHz / 9600).
- HALF_T, 26: sample-point offset within a bit period. Must satisfy 0 < HALF_T < BPS_T; default BPS_T/2.

Ports:
- CLK  input  1  system clock; every flop is clocked on its rising edge.
- RSTn  input  1  synchronous, active-low reset.
- RX_Pin_In  input  1  asynchronous serial line; idles high.
- RX_En_Sig  input  1  receive enable; low forces idle.
- RX_Data  output  8  last correctly framed byte; held until the next good frame.
- RX_Done_Sig  output  1  one-cycle strobe when RX_Data is updated.
- Frame_Err_Sig  output  1  one-cycle strobe when the stop bit is sampled low.
- RX_Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: sampled on the CLK rising edge while RSTn = 0. All of the following take effect on that edge:
  - synchroniser flops <= 1;
  - state <= IDLE;
  - Count <= 0; bit index <= 0; shift register <= 0;
  - RX_Data <= 8'h00; RX_Done_Sig, Frame_Err_Sig, RX_Busy <= 0.
- Reset mid-frame: aborts with no strobe.
- Synchroniser: two flops on RX_Pin_In; a third flop keeps the previous synced value for edge detection. Only the synced line (RXs) is used internally.
- Count is 13 bits. It increments every cycle in START, DATA and STOP, and wraps from BPS_T-1 to 0. On each wrap, bit index increments.
- Sample point: the cycle where Count == HALF_T.
- States:
  - IDLE: when RX_En_Sig = 1 and an RXs 1->0 edge is seen (cycle c0) -> START, with Count = 0 and bit index = 0 at c0+1. No edge, or RX_En_Sig = 0 -> stay in IDLE.
  - START: at the sample point, RXs = 0 -> continue; RXs = 1 -> glitch, go to IDLE with no strobes. At the wrap -> DATA.
  - DATA: at the sample point of bit index i (0..7), shift RXs into data bit i (LSB first). At the wrap after bit 7 -> STOP.
  - STOP: at the sample point, RXs = 1 -> load RX_Data from the shift register and pulse RX_Done_Sig on the next cycle, then go to IDLE immediately (half-bit early, for resync).
  - STOP with RXs = 0 at the sample point -> pulse Frame_Err_Sig on the next cycle and leave RX_Data unchanged. Go to WAIT_HIGH, which returns to IDLE only once RXs = 1 (break/line-low case; no new start is detected during a break).
- Latency: RX_Done_Sig (or Frame_Err_Sig) is high exactly in cycle c0 + 2 + 9*BPS_T + HALF_T = c0+496 at the defaults.
- RX_Done_Sig and Frame_Err_Sig are never high together. Each is high for exactly one cycle per frame.
- RX_En_Sig = 0 in any non-IDLE state -> IDLE on the next edge, no strobe, RX_Data unchanged.
- Back-to-back frames: a start edge that arrives half a bit after the stop sample is accepted; no idle gap is required.
- Enable and edge in the same cycle: the edge is ignored when RX_En_Sig = 0.

Test Plan:
- Reset then send 8'hA5 at 52 clk/bit -> RX_Done_Sig high for 1 cycle at c0+496, RX_Data = 8'hA5, Frame_Err_Sig stays 0, RX_Busy falls in the same cycle as the done strobe.
- Send 8'h3C then 8'hC3 back-to-back (stop bit of one-bit length) -> two done strobes 520 cycles apart, data 8'h3C then 8'hC3.
- Send 8'h55 with the stop bit driven 0 -> Frame_Err_Sig pulses once, RX_Data keeps its prior value; hold the line low 200 cycles -> no new frame. Release high, send 8'h0F -> done, RX_Data = 8'h0F.
- Low glitch of 10 cycles on an idle line -> RX_Busy high, then low after the START sample; no strobes, RX_Data unchanged.
- Drop RX_En_Sig during data bit 4 of 8'hFF -> IDLE next cycle, no strobes. With RX_En_Sig held low, send a full frame -> ignored.
- Assert RSTn = 0 mid-frame during bit 6 -> all outputs 0 after the next edge, no strobe. Release reset and send 8'h81 -> received correctly.
